// File: rtl/aes_key_expand_128.sv
// Iterative AES-128 key schedule: emits round keys 0..10 on consecutive
// cycles after an accepted start, one 128-bit key per cycle, no backpressure.

// Combinational AES forward S-box lookup.
module aes_key_expand_128_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  // Row 0 of the table (entries 0x00..0x0f) occupies the most significant bits.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry n sits at bit offset 8*(255-n); 255-n is simply ~n for 8-bit n.
  logic [10:0] base;

  // Table lookup by part-select.
  always_comb begin
    base  = {~in_i, 3'b000};
    out_o = SBOX_TBL[base +: 8];
  end
endmodule

module aes_key_expand_128 #(
  parameter int          NR     = 10,
  parameter logic [7:0]  RCON_0 = 8'h01
) (
  input  logic         iClk,
  input  logic         iRsn,
  input  logic         iStart,
  input  logic [127:0] iKey,
  output logic [127:0] oRoundKey,
  output logic [3:0]   oRoundNum,
  output logic         oRkValid,
  output logic         oBusy,
  output logic         oDone
);
  localparam logic [3:0] LAST_ROUND = 4'(NR);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [127:0]  rk_q, rk_d;
  logic [3:0]    rnum_q, rnum_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    rcon_q, rcon_d;

  // Round-function datapath, derived from the current round key.
  logic [31:0]   w0, w1, w2, w3;
  logic [31:0]   rot_w, sub_w, t_w;
  logic [31:0]   nw0, nw1, nw2, nw3;
  logic [7:0]    rcon_xtime;

  assign w0    = rk_q[127:96];
  assign w1    = rk_q[95:64];
  assign w2    = rk_q[63:32];
  assign w3    = rk_q[31:0];
  assign rot_w = {w3[23:0], w3[31:24]};

  // SubWord: one S-box per byte of the rotated last word.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_subword
      aes_key_expand_128_sbox u_sbox (
        .in_i  (rot_w[8*gi +: 8]),
        .out_o (sub_w[8*gi +: 8])
      );
    end
  endgenerate

  assign t_w = sub_w ^ {rcon_q, 24'h000000};
  assign nw0 = w0 ^ t_w;
  assign nw1 = w1 ^ nw0;
  assign nw2 = w2 ^ nw1;
  assign nw3 = w3 ^ nw2;

  // Multiply Rcon by x in GF(2^8).
  assign rcon_xtime = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  // Next-state logic: accept a start in IDLE, step one round per cycle in EXPAND.
  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    rnum_d  = rnum_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rcon_d  = rcon_q;
    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          rk_d    = iKey;
          rnum_d  = 4'd0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          rcon_d  = RCON_0;
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        if (rnum_q < LAST_ROUND) begin
          rk_d    = {nw0, nw1, nw2, nw3};
          rnum_d  = rnum_q + 4'd1;
          valid_d = 1'b1;
          done_d  = (rnum_q == LAST_ROUND - 4'd1);
          // Leave Rcon at its final value (0x36) instead of stepping past it.
          if (rnum_q != LAST_ROUND - 4'd1) begin
            rcon_d = rcon_xtime;
          end
        end else begin
          // Final key has been presented; key and index hold their values.
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state_q <= ST_IDLE;
      rk_q    <= '0;
      rnum_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rcon_q  <= RCON_0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      rnum_q  <= rnum_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rcon_q  <= rcon_d;
    end
  end

  assign oRoundKey = rk_q;
  assign oRoundNum = rnum_q;
  assign oRkValid  = valid_q;
  assign oBusy     = busy_q;
  assign oDone     = done_q;
endmodule
